// File: rtl/p405s_icu_lfb_pkg.sv
// Shared definitions for the ICU line-fill buffer: geometry, FSM encoding
// and modulo-WORDS index arithmetic.
package p405s_icu_lfb_pkg;

  localparam int WORDS = 8;
  localparam int IDXW  = 3;
  localparam int DW    = 32;

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [0:DW-1]   word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_DRAIN = 2'b10
  } lfb_state_t;

  // Wraps naturally because idx_t is exactly log2(WORDS) bits wide.
  function automatic idx_t idx_inc(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/p405s_icu_lfb_rd_if.sv
// PLB fill, fetch and array-write signals of the line-fill buffer read side.
interface p405s_icu_lfb_rd_if;
  import p405s_icu_lfb_pkg::*;

  logic  fill_start;
  idx_t  fill_crit_idx;
  logic  fill_wr_val;
  word_t fill_wr_data;
  logic  fetch_req;
  idx_t  fetch_idx;
  logic  fetch_hit;
  word_t fetch_data;
  logic  arr_wr_val;
  idx_t  arr_wr_idx;
  word_t arr_wr_data;
  logic  arr_wr_ack;
  logic  fill_busy;
  logic  fill_done;

  modport slave (
    input  fill_start, fill_crit_idx, fill_wr_val, fill_wr_data,
    input  fetch_req, fetch_idx, arr_wr_ack,
    output fetch_hit, fetch_data, arr_wr_val, arr_wr_idx, arr_wr_data,
    output fill_busy, fill_done
  );

  modport master (
    output fill_start, fill_crit_idx, fill_wr_val, fill_wr_data,
    output fetch_req, fetch_idx, arr_wr_ack,
    input  fetch_hit, fetch_data, arr_wr_val, arr_wr_idx, arr_wr_data,
    input  fill_busy, fill_done
  );

endinterface

// File: rtl/p405s_icu_lfb_word.sv
// One line-fill buffer word: unreset data storage plus a reset valid bit.
module p405s_icu_lfb_word
  import p405s_icu_lfb_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_clr,
  input  logic  i_we,
  input  word_t i_data,
  output word_t o_data,
  output logic  o_vld
);

  word_t r_data;
  logic  r_vld;

  always_ff @(posedge i_clk) begin
    if (i_we) r_data <= i_data;
  end

  // Clear (new fill in IDLE) and write (FILL) are never active together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_vld <= 1'b0;
    else if (i_clr) r_vld <= 1'b0;
    else if (i_we)  r_vld <= 1'b1;
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/p405s_icu_lfb_rd.sv
// ICU line-fill buffer, read side: captures a critical-word-first line, serves
// early fetches per word, then drains the full line into the I-cache array.
module p405s_icu_lfb_rd
  import p405s_icu_lfb_pkg::*;
(
  input  logic                      CB,
  input  logic                      RST_N,
  p405s_icu_lfb_rd_if.slave         lfb
);

  localparam logic [IDXW:0] LAST_CNT = (IDXW+1)'(WORDS - 1);
  localparam idx_t          LAST_IDX = idx_t'(WORDS - 1);

  lfb_state_t      r_state, w_state_nxt;
  idx_t            r_wptr, w_wptr_nxt;
  logic [IDXW:0]   r_wcnt, w_wcnt_nxt;
  idx_t            r_didx, w_didx_nxt;
  logic            r_done, w_done_nxt;
  logic            r_fetch_hit;
  word_t           r_fetch_data;

  word_t           w_word [WORDS];
  logic [WORDS-1:0] w_vld;
  logic [WORDS-1:0] w_we;
  logic            w_clr;
  logic            w_wr_take;
  logic            w_drain;
  logic            w_byp;
  logic            w_fvld;

  assign w_wr_take = (r_state == ST_FILL) && lfb.fill_wr_val;
  assign w_clr     = (r_state == ST_IDLE) && lfb.fill_start;
  assign w_drain   = (r_state == ST_DRAIN);

  always_comb begin
    w_we = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_we[i] = w_wr_take && (r_wptr == idx_t'(i));
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_word
    p405s_icu_lfb_word u_word (
      .i_clk   (CB),
      .i_rst_n (RST_N),
      .i_clr   (w_clr),
      .i_we    (w_we[g]),
      .i_data  (lfb.fill_wr_data),
      .o_data  (w_word[g]),
      .o_vld   (w_vld[g])
    );
  end

  always_ff @(posedge CB or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_wcnt  <= '0;
      r_didx  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_didx  <= w_didx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_wcnt_nxt  = r_wcnt;
    w_didx_nxt  = r_didx;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (lfb.fill_start) begin
          w_state_nxt = ST_FILL;
          w_wptr_nxt  = lfb.fill_crit_idx;
          w_wcnt_nxt  = '0;
        end
      end
      ST_FILL: begin
        if (lfb.fill_wr_val) begin
          w_wptr_nxt = idx_inc(r_wptr);
          w_wcnt_nxt = r_wcnt + 1'b1;
          if (r_wcnt == LAST_CNT) begin
            w_state_nxt = ST_DRAIN;
            w_didx_nxt  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (lfb.arr_wr_ack) begin
          w_didx_nxt = idx_inc(r_didx);
          if (r_didx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The word being written this cycle is forwarded so a fetch racing its
  // arrival does not have to wait a cycle for the valid bit.
  assign w_byp  = w_wr_take && (r_wptr == lfb.fetch_idx);
  assign w_fvld = w_vld[lfb.fetch_idx];

  always_ff @(posedge CB or negedge RST_N) begin
    if (!RST_N) begin
      r_fetch_hit  <= 1'b0;
      r_fetch_data <= '0;
    end else if (lfb.fetch_req) begin
      r_fetch_hit  <= w_byp || w_fvld;
      if (w_byp)       r_fetch_data <= lfb.fill_wr_data;
      else if (w_fvld) r_fetch_data <= w_word[lfb.fetch_idx];
      else             r_fetch_data <= '0;
    end else begin
      r_fetch_hit  <= 1'b0;
    end
  end

  assign lfb.fetch_hit   = r_fetch_hit;
  assign lfb.fetch_data  = r_fetch_data;
  assign lfb.arr_wr_val  = w_drain;
  assign lfb.arr_wr_idx  = w_drain ? r_didx : '0;
  assign lfb.arr_wr_data = w_drain ? w_word[r_didx] : '0;
  assign lfb.fill_busy   = (r_state != ST_IDLE);
  assign lfb.fill_done   = r_done;

endmodule

// File: tb/tb_p405s_icu_lfb_rd.sv
// Directed bench for the ICU line-fill buffer read side: a cycle table for the
// main fill/drain sequence plus hand-written reset-abort and refill sequences.
module tb_p405s_icu_lfb_rd;

  logic CB;
  logic RST_N;
  int   checks;
  int   failures;

  p405s_icu_lfb_rd_if lfb();

  p405s_icu_lfb_rd dut (
    .CB    (CB),
    .RST_N (RST_N),
    .lfb   (lfb.slave)
  );

  initial begin
    CB = 1'b0;
    forever #5 CB = ~CB;
  end

  typedef struct {
    logic        fs;
    logic [2:0]  crit;
    logic        wv;
    logic [31:0] wd;
    logic        fr;
    logic [2:0]  fi;
    logic        ack;
    logic        e_hit;
    logic [31:0] e_data;
    logic        e_val;
    logic [2:0]  e_idx;
    logic [31:0] e_adata;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit fs, int crit, bit wv, logic [31:0] wd,
                              bit fr, int fi, bit ack,
                              bit eh, logic [31:0] ed,
                              bit ev, int ei, logic [31:0] eda,
                              bit eb, bit edn);
    vec_t v;
    v.fs = fs;   v.crit = 3'(crit); v.wv = wv;   v.wd = wd;
    v.fr = fr;   v.fi = 3'(fi);     v.ack = ack;
    v.e_hit = eh; v.e_data = ed;    v.e_val = ev; v.e_idx = 3'(ei);
    v.e_adata = eda; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lfb.fill_start    = 1'b0;
    lfb.fill_crit_idx = '0;
    lfb.fill_wr_val   = 1'b0;
    lfb.fill_wr_data  = '0;
    lfb.fetch_req     = 1'b0;
    lfb.fetch_idx     = '0;
    lfb.arr_wr_ack    = 1'b0;
  endtask

  task automatic step();
    @(posedge CB);
    #1;
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, " hit"},   32'(lfb.fetch_hit),   32'h0);
    chk({tag, " data"},  32'(lfb.fetch_data),  32'h0);
    chk({tag, " aval"},  32'(lfb.arr_wr_val),  32'h0);
    chk({tag, " aidx"},  32'(lfb.arr_wr_idx),  32'h0);
    chk({tag, " adata"}, 32'(lfb.arr_wr_data), 32'h0);
    chk({tag, " busy"},  32'(lfb.fill_busy),   32'h0);
    chk({tag, " done"},  32'(lfb.fill_done),   32'h0);
  endtask

  function automatic logic [31:0] wa(int k);
    return 32'hA000_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] wb(int k);
    return 32'hB000_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] wc(int k);
    return (k == 6) ? 32'hDEAD_BEEF : (32'hC000_0000 | 32'(k));
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    RST_N    = 1'b0;
    idle_inputs();

    // Fill from crit 5, fetches racing and preceding word arrival, a stray
    // fill_start in FILL and DRAIN, an ack stall at index 3, then re-fill.
    tbl.push_back(mk(1,5, 0,0,       0,0, 0,  0,0,       0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(5),   0,0, 0,  0,0,       0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(6),   1,6, 0,  1,wa(6),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(7),   1,2, 0,  0,0,       0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(0),   1,5, 0,  1,wa(5),   0,0,0,       1,0));
    tbl.push_back(mk(1,2, 1,wa(1),   0,0, 0,  0,wa(5),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(2),   1,2, 0,  1,wa(2),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(3),   0,0, 0,  0,wa(2),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wa(4),   0,0, 0,  0,wa(2),   1,0,wa(0),   1,0));
    tbl.push_back(mk(0,0, 0,0,       0,0, 1,  0,wa(2),   1,1,wa(1),   1,0));
    tbl.push_back(mk(0,0, 0,0,       0,0, 1,  0,wa(2),   1,2,wa(2),   1,0));
    tbl.push_back(mk(0,0, 0,0,       0,0, 1,  0,wa(2),   1,3,wa(3),   1,0));
    for (int s = 0; s < 3; s++)
      tbl.push_back(mk(0,0, 0,0,     0,0, 0,  0,wa(2),   1,3,wa(3),   1,0));
    tbl.push_back(mk(0,0, 0,0,       0,0, 1,  0,wa(2),   1,4,wa(4),   1,0));
    tbl.push_back(mk(1,6, 0,0,       0,0, 1,  0,wa(2),   1,5,wa(5),   1,0));
    tbl.push_back(mk(0,0, 0,0,       1,6, 1,  1,wa(6),   1,6,wa(6),   1,0));
    tbl.push_back(mk(0,0, 0,0,       0,0, 1,  0,wa(6),   1,7,wa(7),   1,0));
    tbl.push_back(mk(0,0, 0,0,       0,0, 1,  0,wa(6),   0,0,0,       0,1));
    tbl.push_back(mk(0,0, 0,0,       1,7, 1,  1,wa(7),   0,0,0,       0,0));
    tbl.push_back(mk(1,0, 0,0,       1,3, 0,  1,wa(3),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 0,0,       1,7, 0,  0,0,       0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wb(0),   0,0, 0,  0,0,       0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wb(1),   1,0, 0,  1,wb(0),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wb(2),   0,0, 0,  0,wb(0),   0,0,0,       1,0));
    tbl.push_back(mk(0,0, 1,wb(3),   0,0, 0,  0,wb(0),   0,0,0,       1,0));

    step();
    step();
    chk_outs_zero("reset");
    @(negedge CB);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      lfb.fill_start    = tbl[i].fs;
      lfb.fill_crit_idx = tbl[i].crit;
      lfb.fill_wr_val   = tbl[i].wv;
      lfb.fill_wr_data  = tbl[i].wd;
      lfb.fetch_req     = tbl[i].fr;
      lfb.fetch_idx     = tbl[i].fi;
      lfb.arr_wr_ack    = tbl[i].ack;
      step();
      chk($sformatf("row%0d hit", i),   32'(lfb.fetch_hit),   32'(tbl[i].e_hit));
      chk($sformatf("row%0d data", i),  32'(lfb.fetch_data),  tbl[i].e_data);
      chk($sformatf("row%0d aval", i),  32'(lfb.arr_wr_val),  32'(tbl[i].e_val));
      chk($sformatf("row%0d aidx", i),  32'(lfb.arr_wr_idx),  32'(tbl[i].e_idx));
      chk($sformatf("row%0d adata", i), 32'(lfb.arr_wr_data), tbl[i].e_adata);
      chk($sformatf("row%0d busy", i),  32'(lfb.fill_busy),   32'(tbl[i].e_busy));
      chk($sformatf("row%0d done", i),  32'(lfb.fill_done),   32'(tbl[i].e_done));
    end
    idle_inputs();

    // Mid-fill abort: reset lands between clock edges and must act at once.
    @(negedge CB);
    RST_N = 1'b0;
    #1;
    chk_outs_zero("async_rst");
    @(negedge CB);
    RST_N = 1'b1;
    lfb.fetch_req = 1'b1;
    lfb.fetch_idx = 3'd1;
    step();
    chk("post_rst valid1 hit", 32'(lfb.fetch_hit), 32'h0);
    chk("post_rst done", 32'(lfb.fill_done), 32'h0);

    // Refill from crit 0 with a racing fetch of word 6 and an early miss on 3.
    idle_inputs();
    lfb.fill_start = 1'b1;
    step();
    chk("refill busy", 32'(lfb.fill_busy), 32'h1);
    lfb.fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lfb.fill_wr_val  = 1'b1;
      lfb.fill_wr_data = wc(k);
      lfb.fetch_req    = (k == 6) || (k == 2);
      lfb.fetch_idx    = (k == 6) ? 3'd6 : 3'd3;
      step();
      if (k == 6) begin
        chk("bypass6 hit", 32'(lfb.fetch_hit), 32'h1);
        chk("bypass6 data", lfb.fetch_data, 32'hDEAD_BEEF);
      end
      if (k == 2) begin
        chk("early3 hit", 32'(lfb.fetch_hit), 32'h0);
        chk("early3 data", lfb.fetch_data, 32'h0);
      end
      if (k < 7) chk($sformatf("refill w%0d aval", k), 32'(lfb.arr_wr_val), 32'h0);
    end
    idle_inputs();
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("drain%0d aval", d),  32'(lfb.arr_wr_val),  32'h1);
      chk($sformatf("drain%0d aidx", d),  32'(lfb.arr_wr_idx),  32'(d));
      chk($sformatf("drain%0d adata", d), lfb.arr_wr_data,      wc(d));
      chk($sformatf("drain%0d done", d),  32'(lfb.fill_done),   32'h0);
      lfb.arr_wr_ack = 1'b1;
      step();
    end
    lfb.arr_wr_ack = 1'b0;
    chk("refill done", 32'(lfb.fill_done), 32'h1);
    chk("refill idle aval", 32'(lfb.arr_wr_val), 32'h0);
    chk("refill idle busy", 32'(lfb.fill_busy), 32'h0);
    lfb.fetch_req = 1'b1;
    lfb.fetch_idx = 3'd7;
    step();
    chk("done one-cycle", 32'(lfb.fill_done), 32'h0);
    chk("readback7 hit", 32'(lfb.fetch_hit), 32'h1);
    chk("readback7 data", lfb.fetch_data, 32'hC000_0007);
    idle_inputs();
    step();
    chk("req low hit", 32'(lfb.fetch_hit), 32'h0);
    chk("req low data hold", lfb.fetch_data, 32'hC000_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
